// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop input synchroniser feeding a
// small first-word-fall-through receive FIFO with sticky overrun/framing flags.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       rd,
   input  logic       clr,
   output logic [7:0] rx_data,
   output logic       empty,
   output logic       full,
   output logic       overrun,
   output logic       ferr
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   logic [1:0]    sync_r;
   logic          rxs_s;

   state_t        state_r, state_s;
   logic [CW-1:0] baud_cnt_r, baud_cnt_s;
   logic [2:0]    bit_idx_r, bit_idx_s;
   logic [7:0]    shreg_r, shreg_s;
   logic          push_s;
   logic          ferr_set_s;

   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
   logic          empty_s, full_s, empty_nxt_s, full_nxt_s;
   logic          pop_s, wr_en_s, ovr_set_s;
   logic [7:0]    head_s;

   logic [7:0]    rx_data_r;
   logic          empty_r, full_r, overrun_r, ferr_r;

   // rxd is asynchronous to clk; idle-high reset value avoids a false start bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], rxd};
      end
   end

   assign rxs_s = sync_r[1];

   // Receiver state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         baud_cnt_r <= CNT_ZERO;
         bit_idx_r  <= 3'd0;
         shreg_r    <= 8'h00;
      end else begin
         state_r    <= state_s;
         baud_cnt_r <= baud_cnt_s;
         bit_idx_r  <= bit_idx_s;
         shreg_r    <= shreg_s;
      end
   end

   // Receiver next-state: half-bit start qualification, then mid-bit sampling
   always_comb begin
      state_s    = state_r;
      baud_cnt_s = baud_cnt_r + CNT_ONE;
      bit_idx_s  = bit_idx_r;
      shreg_s    = shreg_r;
      push_s     = 1'b0;
      ferr_set_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            baud_cnt_s = CNT_ZERO;
            if (!rxs_s) begin
               state_s = ST_START;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (baud_cnt_r == HALF_LAST) begin
               baud_cnt_s = CNT_ZERO;
               bit_idx_s  = 3'd0;
               if (!rxs_s) begin
                  state_s = ST_DATA;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (baud_cnt_r == BIT_LAST) begin
               baud_cnt_s = CNT_ZERO;
               shreg_s    = {rxs_s, shreg_r[7:1]};
               if (bit_idx_r == 3'd7) begin
                  state_s = ST_STOP;
               end else begin
                  bit_idx_s = bit_idx_r + 3'd1;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_STOP: begin
            if (baud_cnt_r == BIT_LAST) begin
               baud_cnt_s = CNT_ZERO;
               if (rxs_s) begin
                  push_s  = 1'b1;
                  state_s = ST_IDLE;
               end else begin
                  ferr_set_s = 1'b1;
                  state_s    = ST_BREAK;
               end
            end else begin
               state_s = ST_STOP;
            end
         end
         ST_BREAK: begin
            // A held-low line stays here so it raises only one framing error
            baud_cnt_s = CNT_ZERO;
            if (rxs_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_BREAK;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            baud_cnt_s = CNT_ZERO;
         end
      endcase
   end

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);

   // FIFO control: a pop frees the slot for a simultaneous push when full
   always_comb begin
      pop_s       = rd & ~empty_s;
      wr_en_s     = push_s & (~full_s | pop_s);
      ovr_set_s   = push_s & full_s & ~rd;
      wr_ptr_s    = wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_s    = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      empty_nxt_s = (wr_ptr_s == rd_ptr_s);
      full_nxt_s  = (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]) && (wr_ptr_s[AW] != rd_ptr_s[AW]);
      head_s      = 8'h00;
      if (empty_nxt_s) begin
         head_s = 8'h00;
      end else if (wr_en_s && (wr_ptr_r[AW-1:0] == rd_ptr_s[AW-1:0])) begin
         head_s = shreg_r;
      end else begin
         head_s = mem_r[rd_ptr_s[AW-1:0]];
      end
   end

   // FIFO storage and pointers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= shreg_r;
         end
         wr_ptr_r <= wr_ptr_s;
         rd_ptr_r <= rd_ptr_s;
      end
   end

   // Registered outputs; sticky flags give priority to a set over clr
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data_r <= 8'h00;
         empty_r   <= 1'b1;
         full_r    <= 1'b0;
         overrun_r <= 1'b0;
         ferr_r    <= 1'b0;
      end else begin
         rx_data_r <= head_s;
         empty_r   <= empty_nxt_s;
         full_r    <= full_nxt_s;
         if (ovr_set_s) begin
            overrun_r <= 1'b1;
         end else if (clr) begin
            overrun_r <= 1'b0;
         end
         if (ferr_set_s) begin
            ferr_r <= 1'b1;
         end else if (clr) begin
            ferr_r <= 1'b0;
         end
      end
   end

   assign rx_data = rx_data_r;
   assign empty   = empty_r;
   assign full    = full_r;
   assign overrun = overrun_r;
   assign ferr    = ferr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed table, hand-written corner sequences and random
// frames checked against a queue-based model of the receive FIFO and flags.
module tb_uart_rx;

   localparam int CPB    = 16;
   localparam int DEPTH  = 4;
   // frame cycle (first edge seeing the start bit = 0) on which the byte lands
   localparam int PUSH_C = 2 + CPB / 2 + 9 * CPB;

   localparam int OP_FRAME = 0;
   localparam int OP_RD    = 1;
   localparam int OP_CLR   = 2;

   logic       clk = 1'b0;
   logic       reset, rxd, rd, clr;
   logic [7:0] rx_data;
   logic       empty, full, overrun, ferr;

   int errors = 0;
   int checks = 0;

   logic [7:0] mq[$];
   bit         m_ovr, m_ferr;

   typedef struct {
      int         op;
      logic [7:0] data;
      bit         stop_ok;
      bit         e_empty;
      bit         e_full;
      logic [7:0] e_data;
      bit         e_ovr;
      bit         e_ferr;
   } vec_t;

   vec_t tbl[12];

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .rxd(rxd), .rd(rd), .clr(clr),
      .rx_data(rx_data), .empty(empty), .full(full), .overrun(overrun), .ferr(ferr)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input bit e_empty, input bit e_full,
                            input logic [7:0] e_data, input bit e_ovr, input bit e_ferr);
      chk({tag, ".empty"},   {7'd0, empty},   {7'd0, e_empty});
      chk({tag, ".full"},    {7'd0, full},    {7'd0, e_full});
      chk({tag, ".rx_data"}, rx_data,         e_data);
      chk({tag, ".overrun"}, {7'd0, overrun}, {7'd0, e_ovr});
      chk({tag, ".ferr"},    {7'd0, ferr},    {7'd0, e_ferr});
   endtask

   task automatic check_model(input string tag);
      check_all(tag, mq.size() == 0, mq.size() == DEPTH,
                (mq.size() > 0) ? mq[0] : 8'h00, m_ovr, m_ferr);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_rd();
      rd = 1'b1;
      @(posedge clk); #1;
      rd = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; rxd = 1'b1; rd = 1'b0; clr = 1'b0;
      idle(2);
      reset = 1'b0;
      idle(2);
      mq.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
   endtask

   // Drives one 10-bit frame, CPB cycles per bit; rd/clr may be pulsed on one
   // chosen frame cycle. rxd is left at the stop-bit level.
   task automatic send_frame(input logic [7:0] data, input bit stop_ok,
                             input int rd_cyc, input int clr_cyc, input bit watch);
      logic [9:0] bits;
      bits = {stop_ok, data, 1'b0};
      for (int c = 0; c < 10 * CPB; c++) begin
         rxd = bits[c / CPB];
         rd  = (c == rd_cyc);
         clr = (c == clr_cyc);
         @(posedge clk); #1;
         if (watch && c == PUSH_C - 1)
            chk("latency.before_push.empty", {7'd0, empty}, 8'h01);
         if (watch && c == PUSH_C) begin
            chk("latency.at_push.empty", {7'd0, empty}, 8'h00);
            chk("latency.at_push.rx_data", rx_data, data);
         end
      end
      rd  = 1'b0;
      clr = 1'b0;
   endtask

   // Frame outcome from the rules: stop high pushes unless the FIFO is full
   // with no pop in the same cycle; stop low is a framing error.
   task automatic model_frame(input logic [7:0] data, input bit stop_ok,
                              input bit rd_p, input bit clr_p);
      bit ovr_set, ferr_set, popped;
      popped   = rd_p && (mq.size() > 0);
      ferr_set = !stop_ok;
      ovr_set  = stop_ok && (mq.size() == DEPTH) && !rd_p;
      if (popped) void'(mq.pop_front());
      if (stop_ok && !ovr_set) mq.push_back(data);
      m_ovr  = ovr_set  ? 1'b1 : (clr_p ? 1'b0 : m_ovr);
      m_ferr = ferr_set ? 1'b1 : (clr_p ? 1'b0 : m_ferr);
   endtask

   initial begin
      logic [7:0] d;
      logic [9:0] bits;
      bit         s_ok, rd_p, clr_p;
      int         op;

      reset = 1'b1; rxd = 1'b1; rd = 1'b0; clr = 1'b0;
      #1;
      check_all("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      do_reset();

      // single byte with exact push-cycle checks, then pop
      send_frame(8'hA5, 1'b1, -1, -1, 1'b1);
      rxd = 1'b1;
      check_all("t1.recv", 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
      pulse_rd();
      check_all("t1.pop", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

      // directed table: back-to-back frames, overrun, ordered reads, ferr
      tbl[0]  = '{OP_FRAME, 8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
      tbl[1]  = '{OP_FRAME, 8'h01, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
      tbl[2]  = '{OP_FRAME, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
      tbl[3]  = '{OP_FRAME, 8'h80, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
      tbl[4]  = '{OP_FRAME, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0};
      tbl[5]  = '{OP_RD,    8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
      tbl[6]  = '{OP_RD,    8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
      tbl[7]  = '{OP_RD,    8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0};
      tbl[8]  = '{OP_RD,    8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[9]  = '{OP_CLR,   8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[10] = '{OP_FRAME, 8'h12, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      tbl[11] = '{OP_CLR,   8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      for (int i = 0; i < 12; i++) begin
         case (tbl[i].op)
            OP_FRAME: send_frame(tbl[i].data, tbl[i].stop_ok, -1, -1, 1'b0);
            OP_RD:    pulse_rd();
            default:  pulse_clr();
         endcase
         check_all($sformatf("tbl%0d", i), tbl[i].e_empty, tbl[i].e_full,
                   tbl[i].e_data, tbl[i].e_ovr, tbl[i].e_ferr);
      end
      rxd = 1'b1;
      idle(8);

      // short low glitch is rejected, and the receiver still takes a frame
      rxd = 1'b0;
      idle(6);
      rxd = 1'b1;
      idle(30);
      check_all("t3.glitch", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b1, -1, -1, 1'b0);
      check_all("t3.after", 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
      pulse_rd();

      // stop bit low, line held low: one ferr event only, nothing pushed
      send_frame(8'h12, 1'b0, -1, -1, 1'b0);
      check_all("t4.ferr", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      idle(20 * CPB);
      pulse_clr();
      check_all("t4.clr_in_break", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(20 * CPB);
      check_all("t4.held_low", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      rxd = 1'b1;
      idle(8);
      send_frame(8'h12, 1'b0, -1, -1, 1'b0);
      idle(40 * CPB);
      check_all("t4.held_again", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      rxd = 1'b1;
      idle(8);
      pulse_clr();
      check_all("t4.release_clr", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

      // full FIFO with rd in the push cycle: pop+push, no overrun
      send_frame(8'h11, 1'b1, -1, -1, 1'b0);
      send_frame(8'h22, 1'b1, -1, -1, 1'b0);
      send_frame(8'h33, 1'b1, -1, -1, 1'b0);
      send_frame(8'h44, 1'b1, -1, -1, 1'b0);
      send_frame(8'h77, 1'b1, PUSH_C, -1, 1'b0);
      check_all("t5.rd_at_push", 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
      pulse_rd(); chk("t5.rd1", rx_data, 8'h33);
      pulse_rd(); chk("t5.rd2", rx_data, 8'h44);
      pulse_rd(); chk("t5.rd3", rx_data, 8'h77);
      pulse_rd(); check_all("t5.drained", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

      // overrun set in the same cycle as clr: the set wins
      send_frame(8'hA1, 1'b1, -1, -1, 1'b0);
      send_frame(8'hA2, 1'b1, -1, -1, 1'b0);
      send_frame(8'hA3, 1'b1, -1, -1, 1'b0);
      send_frame(8'hA4, 1'b1, -1, -1, 1'b0);
      send_frame(8'hA5, 1'b1, -1, PUSH_C, 1'b0);
      check_all("set_wins", 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0);

      // reset in the middle of a data bit, then a clean frame
      bits = {1'b1, 8'hC3, 1'b0};
      for (int c = 0; c < 4 * CPB + 5; c++) begin
         rxd = bits[c / CPB];
         @(posedge clk); #1;
      end
      reset = 1'b1;
      rxd   = 1'b1;
      #1;
      check_all("t6.async_reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(4);
      send_frame(8'h9E, 1'b1, -1, -1, 1'b0);
      check_all("t6.after_reset", 1'b0, 1'b0, 8'h9E, 1'b0, 1'b0);
      pulse_rd();
      check_all("t6.only_one", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 70; i++) begin
         op = $urandom_range(0, 9);
         if (op <= 5) begin
            d     = 8'($urandom);
            s_ok  = ($urandom_range(0, 7) != 0);
            rd_p  = ($urandom_range(0, 3) == 0);
            clr_p = ($urandom_range(0, 3) == 0);
            send_frame(d, s_ok, rd_p ? PUSH_C : -1, clr_p ? PUSH_C : -1, 1'b0);
            model_frame(d, s_ok, rd_p, clr_p);
            check_model($sformatf("rnd%0d.frame", i));
            if (!s_ok) begin
               rxd = 1'b1;
               idle(4);
            end
         end else if (op <= 7) begin
            pulse_rd();
            if (mq.size() > 0) void'(mq.pop_front());
            check_model($sformatf("rnd%0d.rd", i));
         end else if (op == 8) begin
            pulse_clr();
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
            check_model($sformatf("rnd%0d.clr", i));
         end else begin
            idle($urandom_range(1, 20));
            check_model($sformatf("rnd%0d.idle", i));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
